ball_engine: RTL



---
 rtl/ball_engine.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ball_engine.sv
// Pong-style ball engine: ball position, direction and rally count on a 16-LED court.
// Optional BALL_SPEEDUP_EN shortens the step period after each successful return.
module ball_engine #(
  parameter int unsigned TICK_DIV   = 32'd25000000,
  parameter int unsigned MIN_DIV    = 32'd6250000,
  parameter int unsigned SPEED_STEP = 32'd2500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  serve,
  input  logic        right_hit,
  input  logic        left_hit,
  output logic [15:0] light,
  output logic [1:0]  direction,
  output logic        miss_left,
  output logic        miss_right,
  output logic [7:0]  rally
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MOVE_L = 2'b01,
    MOVE_R = 2'b10
  } state_t;

  state_t      r_state;
  logic [15:0] r_light;
  logic        r_miss_left;
  logic        r_miss_right;
  logic [7:0]  r_rally;
  logic [31:0] r_count;
  logic        r_right_prev;
  logic        r_left_prev;

  logic        w_right_edge;
  logic        w_left_edge;
  logic [31:0] w_period;
  logic        w_expire;
  logic        w_start_l;
  logic        w_start_r;
  logic        w_ret_l;
  logic        w_ret_r;

  // Ball parked at the serving player's end while waiting for the serve.
  function automatic logic [15:0] serve_light(input logic [1:0] s);
    logic [15:0] v;
    case (s)
      2'b01:   v = 16'h0001;
      2'b10:   v = 16'h8000;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign w_right_edge = right_hit & ~r_right_prev;
  assign w_left_edge  = left_hit  & ~r_left_prev;
  assign w_expire     = (r_count == (w_period - 32'd1));

  assign w_start_l = (r_state == IDLE)   && (serve == 2'b01) && w_right_edge;
  assign w_start_r = (r_state == IDLE)   && (serve == 2'b10) && w_left_edge;
  // Only the receiving player's edge at their own end counts as a return.
  assign w_ret_l   = (r_state == MOVE_L) && r_light[15] && w_left_edge;
  assign w_ret_r   = (r_state == MOVE_R) && r_light[0]  && w_right_edge;

`ifdef BALL_SPEEDUP_EN
  logic [31:0] r_period;

  assign w_period = r_period;

  // Step period: restored on serve, shortened on each return down to the floor.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_period <= TICK_DIV;
    end else if (w_start_l || w_start_r) begin
      r_period <= TICK_DIV;
    end else if (w_ret_l || w_ret_r) begin
      r_period <= (r_period >= (MIN_DIV + SPEED_STEP)) ? (r_period - SPEED_STEP) : MIN_DIV;
    end else begin
      r_period <= r_period;
    end
  end
`else
  logic w_unused_cfg;

  assign w_period     = TICK_DIV;
  assign w_unused_cfg = ^{MIN_DIV, SPEED_STEP};
`endif

  // Ball FSM: serve, stepping, returns and misses, with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_light      <= 16'h0000;
      r_miss_left  <= 1'b0;
      r_miss_right <= 1'b0;
      r_rally      <= 8'd0;
      r_count      <= 32'd0;
      r_right_prev <= 1'b0;
      r_left_prev  <= 1'b0;
    end else begin
      r_right_prev <= right_hit;
      r_left_prev  <= left_hit;
      r_miss_left  <= 1'b0;
      r_miss_right <= 1'b0;
      case (r_state)
        IDLE: begin
          r_count <= 32'd0;
          if (w_start_l) begin
            r_state <= MOVE_L;
            r_light <= 16'h0001;
            r_rally <= 8'd0;
          end else if (w_start_r) begin
            r_state <= MOVE_R;
            r_light <= 16'h8000;
            r_rally <= 8'd0;
          end else begin
            r_light <= serve_light(serve);
          end
        end
        MOVE_L: begin
          // A return on the expiry cycle still counts: the hit is tested first.
          if (w_ret_l) begin
            r_state <= MOVE_R;
            r_count <= 32'd0;
            r_rally <= sat_inc(r_rally);
          end else if (w_expire) begin
            r_count <= 32'd0;
            if (r_light[15]) begin
              r_state     <= IDLE;
              r_miss_left <= 1'b1;
              r_light     <= serve_light(serve);
            end else begin
              r_light <= r_light << 1;
            end
          end else begin
            r_count <= r_count + 32'd1;
          end
        end
        MOVE_R: begin
          if (w_ret_r) begin
            r_state <= MOVE_L;
            r_count <= 32'd0;
            r_rally <= sat_inc(r_rally);
          end else if (w_expire) begin
            r_count <= 32'd0;
            if (r_light[0]) begin
              r_state      <= IDLE;
              r_miss_right <= 1'b1;
              r_light      <= serve_light(serve);
            end else begin
              r_light <= r_light >> 1;
            end
          end else begin
            r_count <= r_count + 32'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_light <= 16'h0000;
          r_count <= 32'd0;
        end
      endcase
    end
  end

  assign light      = r_light;
  assign direction  = r_state;
  assign miss_left  = r_miss_left;
  assign miss_right = r_miss_right;
  assign rally      = r_rally;

endmodule
